// File: rtl/stream_to_mem_loader_pkg.sv
// rtl/stream_to_mem_loader_pkg.sv - shared state encoding and lane mapping for the stream loader
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_e;

    // Byte position within the word for the n-th received byte of that word.
    function automatic int unsigned lane_select(
        input int unsigned lane_idx,
        input logic        big_endian,
        input int unsigned lanes
    );
        return big_endian ? (lanes - 1 - lane_idx) : lane_idx;
    endfunction

endpackage

// File: rtl/stream_to_mem_loader_if.sv
// rtl/stream_to_mem_loader_if.sv - byte stream in / byte-enabled memory write port out
interface stream_to_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    localparam int LANES = DATA_W / 8;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              mem_en;
    logic [LANES-1:0]  mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/stream_to_mem_loader_packer.sv
// rtl/stream_to_mem_loader_packer.sv - lane/word counting and registered memory write stage
module byte_lane_packer
    import loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [7:0]            byte_data_i,
    input  logic                  big_endian_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [LEN_W-1:0]      len_words_i,
    output logic                  last_byte_o,
    output logic [LEN_W-1:0]      words_written_o,
    output logic                  mem_en_o,
    output logic [DATA_W/8-1:0]   mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o
);
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SHIFT  = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LANES - 1);

    logic [LANE_W-1:0] lane_idx_q, lane_idx_d;
    logic [LEN_W-1:0]  word_idx_q, word_idx_d;
    logic              word_end;
    int unsigned       lane;
    logic [ADDR_W-1:0] word_addr;

    assign word_end        = (lane_idx_q == LAST_LANE);
    assign last_byte_o     = accept_i && word_end && (word_idx_q == len_words_i - LEN_W'(1));
    assign words_written_o = word_idx_q;
    assign lane            = lane_select(32'(lane_idx_q), big_endian_i, LANES);
    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign word_addr       = (base_addr_i & ALIGN_MASK) + (ADDR_W'(word_idx_q) << SHIFT);

    always_comb begin
        lane_idx_d = lane_idx_q;
        word_idx_d = word_idx_q;
        if (clear_i) begin
            lane_idx_d = '0;
            word_idx_d = '0;
        end else if (accept_i) begin
            if (word_end) begin
                lane_idx_d = '0;
                if (word_idx_q != len_words_i) begin
                    word_idx_d = word_idx_q + LEN_W'(1);
                end
            end else begin
                lane_idx_d = lane_idx_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane_idx_q  <= '0;
            word_idx_q  <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            lane_idx_q <= lane_idx_d;
            word_idx_q <= word_idx_d;
            mem_en_o   <= accept_i;
            if (accept_i) begin
                mem_we_o    <= LANES'(1) << lane;
                mem_addr_o  <= word_addr;
                mem_wdata_o <= DATA_W'(byte_data_i) << (8 * lane);
            end else begin
                mem_we_o    <= '0;
                mem_addr_o  <= '0;
                mem_wdata_o <= '0;
            end
        end
    end

endmodule

// File: rtl/stream_to_mem_loader.sv
// rtl/stream_to_mem_loader.sv - start/abort FSM loading a byte stream into word memory
module stream_to_mem_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [LEN_W-1:0]       len_words,
    input  logic                   big_endian,
    stream_to_mem_loader_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_W-1:0]       words_written
);
    load_state_e       state_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic              endian_q;
    logic              busy_q;
    logic              done_q;
    logic              start_ok;
    logic              accept;
    logic              last_byte;

    // Abort wins over both a new start and an incoming byte.
    assign start_ok = start && !abort && (state_q != LOAD);
    assign accept   = bus.byte_valid && !abort && (state_q == LOAD);
    assign busy     = busy_q;
    assign done     = done_q;

    byte_lane_packer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_packer (
        .clock           (clock),
        .reset_n         (reset_n),
        .clear_i         (start_ok),
        .accept_i        (accept),
        .byte_data_i     (bus.byte_data),
        .big_endian_i    (endian_q),
        .base_addr_i     (base_q),
        .len_words_i     (len_q),
        .last_byte_o     (last_byte),
        .words_written_o (words_written),
        .mem_en_o        (bus.mem_en),
        .mem_we_o        (bus.mem_we),
        .mem_addr_o      (bus.mem_addr),
        .mem_wdata_o     (bus.mem_wdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            endian_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start_ok) begin
                            base_q   <= base_addr;
                            len_q    <= len_words;
                            endian_q <= big_endian;
                            if (len_words == '0) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= LOAD;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        // done lines up with the registered final write.
                        if (last_byte) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_to_mem_loader.sv
// tb/tb_stream_to_mem_loader.sv - directed self-checking bench for stream_to_mem_loader
module tb_stream_to_mem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        done;
    } wr32_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  we;
        logic [63:0] wdata;
        logic        done;
    } wr64_t;

    logic        clock;
    logic        reset_n;
    logic        start32, abort32, be32;
    logic [31:0] base32;
    logic [15:0] len32;
    logic        busy32, done32;
    logic [15:0] ww32;
    logic        start64, abort64, be64;
    logic [31:0] base64;
    logic [15:0] len64;
    logic        busy64, done64;
    logic [15:0] ww64;

    int    n_tests;
    int    n_fail;
    int    done_cnt32;
    int    done_cnt64;
    wr32_t wq32[$];
    wr64_t wq64[$];

    stream_to_mem_loader_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    stream_to_mem_loader_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    stream_to_mem_loader #(.DATA_W(32), .ADDR_W(32), .LEN_W(16)) dut32 (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start32),
        .abort         (abort32),
        .base_addr     (base32),
        .len_words     (len32),
        .big_endian    (be32),
        .bus           (bus32),
        .busy          (busy32),
        .done          (done32),
        .words_written (ww32)
    );

    stream_to_mem_loader #(.DATA_W(64), .ADDR_W(32), .LEN_W(16)) dut64 (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start64),
        .abort         (abort64),
        .base_addr     (base64),
        .len_words     (len64),
        .big_endian    (be64),
        .bus           (bus64),
        .busy          (busy64),
        .done          (done64),
        .words_written (ww64)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus32.mem_en) wq32.push_back('{bus32.mem_addr, bus32.mem_we, bus32.mem_wdata, done32});
        if (bus64.mem_en) wq64.push_back('{bus64.mem_addr, bus64.mem_we, bus64.mem_wdata, done64});
        if (done32) done_cnt32++;
        if (done64) done_cnt64++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_32(input logic [31:0] b, input logic [15:0] l, input logic e);
        base32 = b; len32 = l; be32 = e; start32 = 1'b1;
        step();
        start32 = 1'b0;
    endtask

    task automatic send32(input logic [7:0] d);
        bus32.byte_valid = 1'b1; bus32.byte_data = d;
        step();
        bus32.byte_valid = 1'b0;
    endtask

    task automatic send64(input logic [7:0] d);
        bus64.byte_valid = 1'b1; bus64.byte_data = d;
        step();
        bus64.byte_valid = 1'b0;
    endtask

    task automatic chk_wr32(input string tag, input int idx, input logic [31:0] addr,
                            input logic [3:0] we, input logic [31:0] wdata);
        wr32_t w;
        if (idx < wq32.size()) w = wq32[idx];
        else begin w.addr = 'x; w.we = 'x; w.wdata = 'x; w.done = 'x; end
        chk({tag, ".addr"}, w.addr, addr);
        chk({tag, ".we"}, w.we, we);
        chk({tag, ".wdata"}, w.wdata, wdata);
    endtask

    initial begin
        int n0;
        int d0;
        wr64_t w;
        n_tests = 0; n_fail = 0;
        reset_n = 1'b0;
        start32 = 0; abort32 = 0; be32 = 0; base32 = '0; len32 = '0;
        start64 = 0; abort64 = 0; be64 = 0; base64 = '0; len64 = '0;
        bus32.byte_valid = 0; bus32.byte_data = '0;
        bus64.byte_valid = 0; bus64.byte_data = '0;
        step(); step();
        chk("rst.busy", busy32, 0);
        chk("rst.done", done32, 0);
        chk("rst.ww", ww32, 0);
        chk("rst.mem_en", bus32.mem_en, 0);
        chk("rst.mem_we", bus32.mem_we, 0);
        reset_n = 1'b1;
        step();

        // little-endian, two words
        n0 = wq32.size(); d0 = done_cnt32;
        start_32(32'h100, 16'd2, 1'b0);
        chk("le.busy", busy32, 1);
        for (int i = 0; i < 8; i++) send32(8'(8'h11 * (i + 1)));
        step(); step();
        chk("le.count", wq32.size() - n0, 8);
        chk_wr32("le.w0", n0 + 0, 32'h100, 4'h1, 32'h0000_0011);
        chk_wr32("le.w3", n0 + 3, 32'h100, 4'h8, 32'h4400_0000);
        chk_wr32("le.w4", n0 + 4, 32'h104, 4'h1, 32'h0000_0055);
        chk_wr32("le.w7", n0 + 7, 32'h104, 4'h8, 32'h8800_0000);
        chk("le.done_on_w7", (wq32.size() > n0 + 7) ? wq32[n0 + 7].done : 1'bx, 1);
        chk("le.done_cnt", done_cnt32 - d0, 1);
        chk("le.ww", ww32, 2);
        chk("le.busy_end", busy32, 0);

        // bytes while in DONE are ignored
        n0 = wq32.size();
        send32(8'hE1); send32(8'hE2);
        step();
        chk("done_ign.count", wq32.size() - n0, 0);
        chk("done_ign.ww", ww32, 2);

        // big-endian with a start pulse in the middle of LOAD
        n0 = wq32.size(); d0 = done_cnt32;
        start_32(32'h100, 16'd2, 1'b1);
        send32(8'h11); send32(8'h22); send32(8'h33);
        base32 = 32'h200; len32 = 16'd5; start32 = 1'b1;
        send32(8'h44);
        start32 = 1'b0;
        send32(8'h55); send32(8'h66); send32(8'h77); send32(8'h88);
        step(); step();
        chk("be.count", wq32.size() - n0, 8);
        chk_wr32("be.w0", n0 + 0, 32'h100, 4'h8, 32'h1100_0000);
        chk_wr32("be.w3", n0 + 3, 32'h100, 4'h1, 32'h0000_0044);
        chk_wr32("be.w4", n0 + 4, 32'h104, 4'h8, 32'h5500_0000);
        chk_wr32("be.w7", n0 + 7, 32'h104, 4'h1, 32'h0000_0088);
        chk("be.done_cnt", done_cnt32 - d0, 1);
        chk("be.ww", ww32, 2);

        // zero-length load
        n0 = wq32.size(); d0 = done_cnt32;
        start_32(32'h100, 16'd0, 1'b0);
        chk("len0.done", done32, 1);
        chk("len0.busy", busy32, 0);
        chk("len0.ww", ww32, 0);
        step();
        chk("len0.done_drop", done32, 0);
        step();
        chk("len0.count", wq32.size() - n0, 0);
        chk("len0.done_cnt", done_cnt32 - d0, 1);

        // abort after five bytes, byte in the abort cycle is dropped
        n0 = wq32.size(); d0 = done_cnt32;
        start_32(32'h300, 16'd4, 1'b0);
        for (int i = 0; i < 5; i++) send32(8'(8'h11 * (i + 1)));
        abort32 = 1'b1;
        send32(8'h66);
        abort32 = 1'b0;
        step(); step();
        chk("abort.count", wq32.size() - n0, 5);
        chk_wr32("abort.w4", n0 + 4, 32'h304, 4'h1, 32'h0000_0055);
        chk("abort.done_cnt", done_cnt32 - d0, 0);
        chk("abort.busy", busy32, 0);
        chk("abort.ww", ww32, 1);
        n0 = wq32.size();
        send32(8'hF1); send32(8'hF2);
        step();
        chk("idle_ign.count", wq32.size() - n0, 0);
        chk("idle_ign.ww", ww32, 1);

        // restart after abort begins again from base
        n0 = wq32.size(); d0 = done_cnt32;
        start_32(32'h300, 16'd1, 1'b0);
        chk("restart.ww_clr", ww32, 0);
        send32(8'hAA); send32(8'hBB); send32(8'hCC); send32(8'hDD);
        step(); step();
        chk("restart.count", wq32.size() - n0, 4);
        chk_wr32("restart.w0", n0 + 0, 32'h300, 4'h1, 32'h0000_00AA);
        chk_wr32("restart.w3", n0 + 3, 32'h300, 4'h8, 32'hDD00_0000);
        chk("restart.done_cnt", done_cnt32 - d0, 1);
        chk("restart.ww", ww32, 1);

        // 64-bit words, address wraps past 2^32
        d0 = done_cnt64;
        base64 = 32'hFFFF_FFF8; len64 = 16'd2; be64 = 1'b0; start64 = 1'b1;
        step();
        start64 = 1'b0;
        for (int i = 0; i < 16; i++) send64(8'(i + 1));
        step(); step();
        chk("w64.count", wq64.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < wq64.size()) w = wq64[i];
            else begin w.addr = 'x; w.we = 'x; w.wdata = 'x; w.done = 'x; end
            chk($sformatf("w64.addr%0d", i), w.addr, (i < 8) ? 32'hFFFF_FFF8 : 32'h0000_0000);
            chk($sformatf("w64.we%0d", i), w.we, 8'h01 << (i % 8));
            chk($sformatf("w64.wdata%0d", i), w.wdata, 64'(i + 1) << (8 * (i % 8)));
        end
        chk("w64.done_last", (wq64.size() > 15) ? wq64[15].done : 1'bx, 1);
        chk("w64.done_cnt", done_cnt64 - d0, 1);
        chk("w64.ww", ww64, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
